rx_dest_arbiter: RTL and testbench

//   Receive-side drain for the two destination queues D0/D1: pops words from whichever queue is
//   non-empty under round-robin, buffers them in an internal output queue and presents one merged
//   6-bit stream with valid/ready to the consumer. Sits at the far end of the tx path
//   (MAIN -> VC0/VC1 -> D0/D1) and keeps per-destination word counts.

---
 rtl/rx_pkg.sv | 20 ++
 rtl/rx_out_buf.sv | 58 +++++
 rtl/rx_dest_arbiter.sv | 132 +++++++++++++
 tb/tb_rx_dest_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rx_pkg
// Purpose  : Shared word layout and arbiter FSM encodings for the rx drain.
// Revision : 1.0
// ============================================================================
package rx_pkg;

  localparam int WORD_W   = 6;
  localparam int VC_BIT   = 5;
  localparam int DEST_BIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP0 = 2'd1,
    ST_POP1 = 2'd2
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/rx_out_buf.sv
`default_nettype none
// ============================================================================
// Module   : rx_out_buf
// Purpose  : Output FIFO of the rx drain; head word is presented combinationally.
// Revision : 1.0
// ============================================================================
module rx_out_buf #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  parameter int PTR   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             deq_i,
  output logic [WIDTH-1:0] data_o,
  output logic [PTR:0]     count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [PTR:0] c_DEPTH = (PTR+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR-1:0]   wr_ptr_q;
  logic [PTR-1:0]   rd_ptr_q;
  logic [PTR:0]     count_q;
  logic             w_wr;
  logic             w_rd;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == c_DEPTH);
  assign count_o = count_q;
  assign w_rd    = deq_i & ~empty_o;
  // A dequeue in the same cycle frees the slot a write into a full buffer needs.
  assign w_wr    = enq_i & (~full_o | w_rd);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_wr) wr_ptr_q <= wr_ptr_q + PTR'(1);
      if (w_rd) rd_ptr_q <= rd_ptr_q + PTR'(1);
      count_q <= count_q + (PTR+1)'(w_wr) - (PTR+1)'(w_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) mem_q[wr_ptr_q] <= data_i;
    if (!rst) assert (!(enq_i && full_o && !w_rd));
  end

endmodule
`default_nettype wire

// File: rtl/rx_dest_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rx_dest_arbiter
// Purpose  : Round-robin drain of destination queues D0/D1 into one buffered
//            valid/ready stream with per-destination word counters.
//            Define RX_CHECK_EN to drop words whose dest bit mismatches the source.
// Revision : 1.0
// ============================================================================
module rx_dest_arbiter
  import rx_pkg::*;
#(
  parameter int OUT_DEPTH = 4,
  parameter int OUT_PTR   = 2,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              D0_EMPTY,
  input  logic              D0_VALID,
  input  logic [WORD_W-1:0] DATA_IN_D0,
  output logic              POP_D0,
  input  logic              D1_EMPTY,
  input  logic              D1_VALID,
  input  logic [WORD_W-1:0] DATA_IN_D1,
  output logic              POP_D1,
  input  logic              READY_IN,
  output logic [WORD_W-1:0] DATA_OUT,
  output logic              VALID_OUT,
  output logic              OUT_FULL,
  output logic [CNT_W-1:0]  CNT_D0,
  output logic [CNT_W-1:0]  CNT_D1,
  output logic              ERR_DEST
);

  localparam logic [OUT_PTR+1:0] c_DEPTH = (OUT_PTR+2)'(OUT_DEPTH);
  localparam logic [OUT_PTR+1:0] c_ONE   = (OUT_PTR+2)'(1);

  rx_state_e          state_q, state_d;
  logic               rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_d0_q, cnt_d1_q;
  logic [WORD_W-1:0]  w_cap_data;
  logic               w_cap_vld;
  logic               w_dest_ok;
  logic               w_enq;
  logic               w_deq;
  logic               w_empty;
  logic               w_room;
  logic               w_avail0;
  logic               w_avail1;
  logic [OUT_PTR:0]   w_occ;
  logic [OUT_PTR+1:0] w_need;

  // Only one pop per cycle is ever issued, so at most one VALID is high.
  assign w_cap_vld  = D0_VALID | D1_VALID;
  assign w_cap_data = D0_VALID ? DATA_IN_D0 : DATA_IN_D1;

`ifdef RX_CHECK_EN
  logic err_q;

  assign w_dest_ok = (w_cap_data[DEST_BIT] == ~D0_VALID);
  assign ERR_DEST  = err_q;

  always_ff @(posedge clk) begin
    if (RESET) err_q <= 1'b0;
    else       err_q <= w_cap_vld & ~w_dest_ok;
  end
`else
  assign w_dest_ok = 1'b1;
  assign ERR_DEST  = 1'b0;
`endif

  assign w_enq     = w_cap_vld & w_dest_ok;
  assign w_deq     = ~w_empty & READY_IN;
  assign VALID_OUT = ~w_empty;
  assign POP_D0    = (state_q == ST_POP0);
  assign POP_D1    = (state_q == ST_POP1);
  assign CNT_D0    = cnt_d0_q;
  assign CNT_D1    = cnt_d1_q;

  // Slots claimed next cycle: post-update occupancy, the pop issued now, and the new pop.
  assign w_need = {1'b0, w_occ} + (OUT_PTR+2)'(w_enq) - (OUT_PTR+2)'(w_deq)
                + (OUT_PTR+2)'(state_q != ST_IDLE) + c_ONE;
  assign w_room = (w_need <= c_DEPTH);

  // EMPTY still reflects the word being popped this cycle, so that queue sits out one cycle.
  assign w_avail0 = ~D0_EMPTY & (state_q != ST_POP0);
  assign w_avail1 = ~D1_EMPTY & (state_q != ST_POP1);

  always_comb begin
    state_d = ST_IDLE;
    rr_d    = rr_q;
    if (w_room) begin
      if (w_avail0 && w_avail1) state_d = rr_q ? ST_POP1 : ST_POP0;
      else if (w_avail0)        state_d = ST_POP0;
      else if (w_avail1)        state_d = ST_POP1;
    end
    if (state_d == ST_POP0)      rr_d = 1'b1;
    else if (state_d == ST_POP1) rr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      rr_q     <= 1'b0;
      cnt_d0_q <= '0;
      cnt_d1_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      if (w_enq && D0_VALID)  cnt_d0_q <= cnt_d0_q + CNT_W'(1);
      if (w_enq && !D0_VALID) cnt_d1_q <= cnt_d1_q + CNT_W'(1);
    end
  end

  rx_out_buf #(
    .WIDTH (WORD_W),
    .DEPTH (OUT_DEPTH),
    .PTR   (OUT_PTR)
  ) u_out_buf (
    .clk     (clk),
    .rst     (RESET),
    .enq_i   (w_enq),
    .data_i  (w_cap_data),
    .deq_i   (w_deq),
    .data_o  (DATA_OUT),
    .count_o (w_occ),
    .full_o  (OUT_FULL),
    .empty_o (w_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_rx_dest_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rx_dest_arbiter
// Purpose  : Scoreboard bench for rx_dest_arbiter with modelled D0/D1 queues.
// Revision : 1.0
// ============================================================================
module tb_rx_dest_arbiter;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       D0_EMPTY = 1'b1, D0_VALID = 1'b0;
  logic       D1_EMPTY = 1'b1, D1_VALID = 1'b0;
  logic       READY_IN = 1'b0;
  logic [5:0] DATA_IN_D0 = '0, DATA_IN_D1 = '0;
  logic [5:0] DATA_OUT;
  logic       POP_D0, POP_D1, VALID_OUT, OUT_FULL, ERR_DEST;
  logic [7:0] CNT_D0, CNT_D1;

  always #5 clk = ~clk;

  rx_dest_arbiter dut (
    .clk        (clk),
    .RESET      (RESET),
    .D0_EMPTY   (D0_EMPTY),
    .D0_VALID   (D0_VALID),
    .DATA_IN_D0 (DATA_IN_D0),
    .POP_D0     (POP_D0),
    .D1_EMPTY   (D1_EMPTY),
    .D1_VALID   (D1_VALID),
    .DATA_IN_D1 (DATA_IN_D1),
    .POP_D1     (POP_D1),
    .READY_IN   (READY_IN),
    .DATA_OUT   (DATA_OUT),
    .VALID_OUT  (VALID_OUT),
    .OUT_FULL   (OUT_FULL),
    .CNT_D0     (CNT_D0),
    .CNT_D1     (CNT_D1),
    .ERR_DEST   (ERR_DEST)
  );

  int tests = 0, fails = 0, cyc = 0;
  int first_pop0 = -1, first_valid = -1;
  int n_out = 0, n_err = 0, pop_seen = 0, bad_pop = 0;
  logic pop0_s = 1'b0, pop1_s = 1'b0;
  logic [5:0] src0[$], src1[$], exp0[$], exp1[$], out_log[$];
  int pop_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [5:0] w);
    src0.push_back(w);
    exp0.push_back(w);
  endtask

  task automatic push1(input logic [5:0] w);
    src1.push_back(w);
    exp1.push_back(w);
  endtask

  task automatic clear_model();
    src0.delete(); src1.delete(); exp0.delete(); exp1.delete();
    out_log.delete(); pop_log.delete();
    n_out = 0; n_err = 0; pop_seen = 0; first_pop0 = -1; first_valid = -1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    clear_model();
    tick(3);
    RESET = 1'b0;
    clear_model();
  endtask

  task automatic wait_drain(input string name, input int limit);
    int k = 0;
    while ((exp0.size() != 0 || exp1.size() != 0 || src0.size() != 0 || src1.size() != 0) && k < limit) begin
      tick(1);
      k++;
    end
    tick(4);
    chk(name, exp0.size() + exp1.size(), 0);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: observe pops and transfers, score outputs against per-source expectations.
  always @(negedge clk) begin
    pop0_s = POP_D0;
    pop1_s = POP_D1;
    if (!RESET) begin
      if (POP_D0) begin
        pop_log.push_back(0);
        if (first_pop0 < 0) first_pop0 = cyc;
      end
      if (POP_D1) pop_log.push_back(1);
      if (POP_D0 || POP_D1) pop_seen++;
      if (VALID_OUT && first_valid < 0) first_valid = cyc;
      if (ERR_DEST) n_err++;
      if (VALID_OUT && READY_IN) begin
        out_log.push_back(DATA_OUT);
        n_out++;
        if (DATA_OUT[4]) begin
          if (exp1.size() == 0) chk("out_extra_d1", {26'd0, DATA_OUT}, 32'hFFFF_FFFF);
          else chk("out_d1_word", {26'd0, DATA_OUT}, {26'd0, exp1.pop_front()});
        end else begin
          if (exp0.size() == 0) chk("out_extra_d0", {26'd0, DATA_OUT}, 32'hFFFF_FFFF);
          else chk("out_d0_word", {26'd0, DATA_OUT}, {26'd0, exp0.pop_front()});
        end
      end
    end
  end

  // Source queue models: a pop seen this cycle yields the word with VALID next cycle.
  always @(posedge clk) begin
    #2;
    D0_VALID = 1'b0;
    D1_VALID = 1'b0;
    if (pop0_s) begin
      if (src0.size() > 0) begin
        DATA_IN_D0 = src0.pop_front();
        D0_VALID   = 1'b1;
      end else if (!RESET) bad_pop++;
    end
    if (pop1_s) begin
      if (src1.size() > 0) begin
        DATA_IN_D1 = src1.pop_front();
        D1_VALID   = 1'b1;
      end else if (!RESET) bad_pop++;
    end
    D0_EMPTY = (src0.size() == 0);
    D1_EMPTY = (src1.size() == 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    int n0, n1;
    logic [5:0] w;

    // Reset state
    RESET = 1'b1;
    tick(3);
    chk("rst_pop_d0", POP_D0, 0);
    chk("rst_pop_d1", POP_D1, 0);
    chk("rst_valid", VALID_OUT, 0);
    chk("rst_data", DATA_OUT, 0);
    chk("rst_full", OUT_FULL, 0);
    chk("rst_cnt_d0", CNT_D0, 0);
    chk("rst_cnt_d1", CNT_D1, 0);
    chk("rst_err", ERR_DEST, 0);
    RESET = 1'b0;
    clear_model();

    // D0 only, in order, latency 2
    READY_IN = 1'b1;
    push0(6'h01); push0(6'h02); push0(6'h03);
    wait_drain("d0_drain", 100);
    chk("d0_latency", first_valid - first_pop0, 2);
    chk("d0_cnt", CNT_D0, 3);
    chk("d0_out_count", out_log.size(), 3);
    if (out_log.size() == 3)
      chk("d0_out_order", {14'd0, out_log[0], out_log[1], out_log[2]}, {14'd0, 6'h01, 6'h02, 6'h03});

    // Both queues loaded: alternate starting from D0 after reset
    do_reset();
    READY_IN = 1'b1;
    push0(6'h05); push0(6'h06); push1(6'h15); push1(6'h16);
    wait_drain("rr_drain", 100);
    chk("rr_pop_count", pop_log.size(), 4);
    if (pop_log.size() == 4)
      chk("rr_pop_order", {pop_log[0][0], pop_log[1][0], pop_log[2][0], pop_log[3][0]}, 4'b0101);
    chk("rr_out_count", out_log.size(), 4);
    if (out_log.size() == 4)
      chk("rr_out_order", {8'd0, out_log[0], out_log[1], out_log[2], out_log[3]},
          {8'd0, 6'h05, 6'h15, 6'h06, 6'h16});

    // Backpressure: buffer fills to depth, pops stall, then all words drain
    do_reset();
    READY_IN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push0(6'h08 + 6'(i));
      push1(6'h10 + 6'(i));
    end
    tick(30);
    chk("bp_full", OUT_FULL, 1);
    chk("bp_valid", VALID_OUT, 1);
    chk("bp_captured", CNT_D0 + CNT_D1, 4);
    pop_seen = 0;
    tick(5);
    chk("bp_no_pop", pop_seen, 0);
    READY_IN = 1'b1;
    wait_drain("bp_drain", 200);
    chk("bp_delivered", n_out, 8);
    chk("bp_cnt_total", CNT_D0 + CNT_D1, 8);
    chk("bp_not_full", OUT_FULL, 0);

    // Reset while a D1 pop is pending
    do_reset();
    READY_IN = 1'b1;
    for (int i = 0; i < 6; i++) push1(6'h30 + 6'(i));
    push0(6'h21);
    k = 0;
    while (!POP_D1 && k < 50) begin
      tick(1);
      k++;
    end
    chk("mid_saw_pop1", POP_D1, 1);
    RESET = 1'b1;
    clear_model();
    tick(1);
    chk("mid_pop_d0", POP_D0, 0);
    chk("mid_pop_d1", POP_D1, 0);
    chk("mid_valid", VALID_OUT, 0);
    chk("mid_cnt_d0", CNT_D0, 0);
    chk("mid_cnt_d1", CNT_D1, 0);
    tick(1);
    RESET = 1'b0;
    clear_model();
    tick(3);
    chk("mid_idle_valid", VALID_OUT, 0);

    // Randomized traffic with backpressure
    do_reset();
    n0 = 0; n1 = 0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) < 30) begin
        w = 6'($urandom); w[4] = 1'b0;
        push0(w); n0++;
      end
      if ($urandom_range(0, 99) < 30) begin
        w = 6'($urandom); w[4] = 1'b1;
        push1(w); n1++;
      end
      READY_IN = ($urandom_range(0, 99) < 70);
      tick(1);
    end
    READY_IN = 1'b1;
    wait_drain("rnd_drain", 2000);
    chk("rnd_cnt_d0", CNT_D0, 8'(n0));
    chk("rnd_cnt_d1", CNT_D1, 8'(n1));
    chk("rnd_out_total", n_out, n0 + n1);

    // Counter wrap
    do_reset();
    READY_IN = 1'b1;
    for (int i = 0; i < 255; i++) push0(6'(i) & 6'h2F);
    wait_drain("wrap_drain", 2000);
    chk("wrap_cnt_ff", CNT_D0, 8'hFF);
    push0(6'h07);
    wait_drain("wrap_drain2", 100);
    chk("wrap_cnt_00", CNT_D0, 8'h00);

`ifdef RX_CHECK_EN
    // Mismatched destination bit from D0 is dropped and flagged
    do_reset();
    READY_IN = 1'b1;
    src0.push_back(6'h12);
    tick(10);
    chk("chk_err_pulses", n_err, 1);
    chk("chk_cnt_d0", CNT_D0, 0);
    chk("chk_no_output", n_out, 0);
`endif

    chk("pop_on_empty", bad_pop, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
